// File: rtl/sobel_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_filter
//  Description : Streaming 3x3 Sobel edge detector. Two line buffers feed a
//                3x3 window; a two-stage pipeline computes |Gx|+|Gy| and
//                saturates it to 8 bits. Border pixels are never emitted.
//                Optional macro SOBEL_THRESHOLD_EN binarizes the output
//                against THRESH.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_filter #(
    parameter int         IMG_W  = 64,
    parameter int         IMG_H  = 64,
    parameter logic [7:0] THRESH = 8'd100
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic [7:0] pixel_i,
    input  logic       valid_i,
    output logic [7:0] grey_o,
    output logic       valid_o,
    output logic       done_o
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          w_col_last, w_row_last, w_win_ok;

    // Line memories: lb0 holds the previous line, lb1 the one before it.
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];

    logic [7:0] p_q [3][3];
    logic       win_valid_q, win_last_q;

    // Gradients kept as 11-bit two's complement values.
    logic [10:0] gx_q, gy_q;
    logic        s1_valid_q, s1_last_q;

    logic [7:0]  grey_q, grey_d;
    logic        valid_q, done_q;

    logic [10:0] w_gx, w_gy, w_ax, w_ay;
    logic [11:0] w_mag;
    logic [7:0]  w_sat;

    assign w_col_last = (col_q == C_COL_LAST);
    assign w_row_last = (row_q == C_ROW_LAST);
    assign w_win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Raster position bookkeeping, advanced only on accepted pixels.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_i) begin
            if (w_col_last) begin
                col_d = '0;
                row_d = w_row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffers shift one line down on every accept (read-before-write, no reset).
    always_ff @(posedge sys_clk_i) begin
        if (valid_i) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= pixel_i;
        end
    end

    // Window shifts left; the new right column is {lb1, lb0, pixel} at this column.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    p_q[r][c] <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            if (valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    p_q[r][0] <= p_q[r][1];
                    p_q[r][1] <= p_q[r][2];
                end
                p_q[0][2] <= lb1[col_q];
                p_q[1][2] <= lb0[col_q];
                p_q[2][2] <= pixel_i;
            end
            win_valid_q <= valid_i && w_win_ok;
            win_last_q  <= valid_i && w_win_ok && w_col_last && w_row_last;
        end
    end

    // Sobel kernels; all terms zero-extended so the subtraction wraps into signed 11 bits.
    assign w_gx = ({3'b000, p_q[0][2]} + {2'b00, p_q[1][2], 1'b0} + {3'b000, p_q[2][2]})
                - ({3'b000, p_q[0][0]} + {2'b00, p_q[1][0], 1'b0} + {3'b000, p_q[2][0]});
    assign w_gy = ({3'b000, p_q[2][0]} + {2'b00, p_q[2][1], 1'b0} + {3'b000, p_q[2][2]})
                - ({3'b000, p_q[0][0]} + {2'b00, p_q[0][1], 1'b0} + {3'b000, p_q[0][2]});

    // Stage 1: register gradients for valid windows, flags every cycle.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            gx_q       <= '0;
            gy_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            if (win_valid_q) begin
                gx_q <= w_gx;
                gy_q <= w_gy;
            end
            s1_valid_q <= win_valid_q;
            s1_last_q  <= win_last_q;
        end
    end

    // |G| magnitude: worst case 1020 still fits the 11-bit absolute value.
    assign w_ax  = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
    assign w_ay  = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
    assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_sat = (|w_mag[11:8]) ? 8'hFF : w_mag[7:0];

`ifdef SOBEL_THRESHOLD_EN
    assign grey_d = (w_sat >= THRESH) ? 8'd255 : 8'd0;
`else
    // THRESH has no function in this build.
    logic [7:0] w_unused_thresh;
    assign w_unused_thresh = THRESH;
    assign grey_d = w_sat;
`endif

    // Stage 2: output register; grey holds between results, strobes are single-cycle.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            grey_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (s1_valid_q)
                grey_q <= grey_d;
            valid_q <= s1_valid_q;
            done_q  <= s1_last_q;
        end
    end

    assign grey_o  = grey_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_filter
//  Description : Directed self-checking bench for sobel_filter on 4x4 frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_filter;

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [7:0] EXP_FLAT = 8'd0;
    localparam logic [7:0] EXP_RAMP = 8'd255;
    localparam logic [7:0] EXP_STEP = 8'd255;
`else
    localparam logic [7:0] EXP_FLAT = 8'd0;
    localparam logic [7:0] EXP_RAMP = 8'd80;
    localparam logic [7:0] EXP_STEP = 8'd255;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pixel_i = 8'd0;
    logic       valid_i = 1'b0;
    logic [7:0] grey_o;
    logic       valid_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] cap_val  [32];
    logic       cap_done [32];
    int         cap_cyc  [32];
    int         cap_n    = 0;
    int         stray    = 0;
    int         win_cyc  [32];
    int         win_n    = 0;

    sobel_filter #(.IMG_W(4), .IMG_H(4), .THRESH(8'd50)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .pixel_i   (pixel_i),
        .valid_i   (valid_i),
        .grey_o    (grey_o),
        .valid_o   (valid_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture results on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o === 1'b1) begin
                if (cap_n < 32) begin
                    cap_val[cap_n]  = grey_o;
                    cap_done[cap_n] = done_o;
                    cap_cyc[cap_n]  = cyc;
                end
                cap_n = cap_n + 1;
            end else if (done_o === 1'b1) begin
                stray = stray + 1;
            end
        end
    end

    function automatic logic [7:0] pix(input int mode, input int c);
        case (mode)
            1:       return 8'(10 * c);
            2:       return 8'(30 - 10 * c);
            3:       return (c >= 2) ? 8'd255 : 8'd0;
            default: return 8'd100;
        endcase
    endfunction

    task automatic drive(input logic [7:0] p, input logic v);
        pixel_i = p;
        valid_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        cap_n = 0;
        stray = 0;
        win_n = 0;
    endtask

    task automatic send_frame(input int mode, input bit gap);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(pix(mode, c), 1'b1);
                if (r >= 2 && c >= 2) begin
                    win_cyc[win_n] = cyc;
                    win_n = win_n + 1;
                end
                if (gap) drive(8'd0, 1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (grey_o !== 8'd0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grey=%0d valid=%b done=%b, required 0/0/0", grey_o, valid_o, done_o);
        end
        rst = 1'b0;
        drive(8'd0, 1'b0);
    endtask

    task automatic test_frame(input string name, input int mode, input logic [7:0] exp);
        clear_capture();
        send_frame(mode, 1'b0);
        idle(5);
        n_checks++;
        if (cap_n !== 4) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs, required 4", name, cap_n);
        end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            n_checks++;
            if (cap_val[i] !== exp || cap_done[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL %s_out%0d: grey=%0d done=%b, required grey=%0d done=%b",
                         name, i, cap_val[i], cap_done[i], exp, (i == 3));
            end
        end
        n_checks++;
        if (stray !== 0 || grey_o !== exp) begin
            n_fail++;
            $display("FAIL %s_hold: stray_done=%0d grey=%0d, required 0 and %0d", name, stray, grey_o, exp);
        end
    endtask

    task automatic test_gaps();
        clear_capture();
        send_frame(0, 1'b1);
        idle(5);
        n_checks++;
        if (cap_n !== 4 || win_n !== 4) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d outputs, required 4", cap_n);
        end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            n_checks++;
            if (cap_val[i] !== EXP_FLAT || cap_cyc[i] - win_cyc[i] !== 2 || cap_done[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL gaps_out%0d: grey=%0d latency=%0d done=%b, required grey=%0d latency=2 done=%b",
                         i, cap_val[i], cap_cyc[i] - win_cyc[i], cap_done[i], EXP_FLAT, (i == 3));
            end
        end
        n_checks++;
        if (cap_n >= 2 && cap_cyc[1] - cap_cyc[0] !== 2) begin
            n_fail++;
            $display("FAIL gaps_spacing: got %0d cycles, required 2", cap_cyc[1] - cap_cyc[0]);
        end
    endtask

    task automatic test_reset_midframe();
        clear_capture();
        for (int i = 0; i < 6; i++) drive(pix(1, i % 4), 1'b1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (grey_o !== 8'd0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: grey=%0d valid=%b done=%b, required 0/0/0", grey_o, valid_o, done_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (cap_n !== 0) begin
            n_fail++;
            $display("FAIL midframe_no_output: got %0d outputs, required 0", cap_n);
        end
        test_frame("after_reset", 1, EXP_RAMP);
    endtask

    task automatic test_back_to_back();
        int ndone;
        clear_capture();
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        idle(5);
        n_checks++;
        if (cap_n !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required 8", cap_n);
        end
        ndone = 0;
        for (int i = 0; i < 8 && i < cap_n; i++) begin
            if (cap_done[i] === 1'b1) ndone++;
            n_checks++;
            if (cap_val[i] !== EXP_RAMP || cap_done[i] !== (i == 3 || i == 7)) begin
                n_fail++;
                $display("FAIL b2b_out%0d: grey=%0d done=%b, required grey=%0d done=%b",
                         i, cap_val[i], cap_done[i], EXP_RAMP, (i == 3 || i == 7));
            end
        end
        n_checks++;
        if (ndone + stray !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_pulses: got %0d, required 2", ndone + stray);
        end
    endtask

    initial begin
        test_reset();
        test_frame("flat", 0, EXP_FLAT);
        test_frame("ramp_up", 1, EXP_RAMP);
        test_frame("ramp_down", 2, EXP_RAMP);
        test_frame("step", 3, EXP_STEP);
        test_gaps();
        test_frame("step2", 3, EXP_STEP);
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
